clock_display_scanner: RTL and testbench
========================================

Name: clock_display_scanner

Overview:
- Consumes the HH:MM BCD digit outputs of the team's digital clock counter and drives a 4-digit multiplexed 7-segment display.
- Latches a coherent time snapshot on a strobe, validates each digit, and time-multiplexes the four digits with an inter-digit blanking cycle.
- Drives a blinking colon and applies optional leading-zero blanking.
- Sits between the clock counter and the board display pins.

Parameters:
- SCAN_DIV, 16: cycles per digit slot, minimum 2.
- BLINK_DIV, 64: scan frames per colon half-period, minimum 1.
- LZ_BLANK, 1: when 1, blank the hour-tens digit if it is 0.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- time_valid  in  1  one-cycle strobe; capture time_* this cycle.
- time_ms_hr  in  2  hour tens (0-2).
- time_ls_hr  in  4  hour units (0-9).
- time_ms_min  in  3  minute tens (0-5).
- time_ls_min  in  4  minute units (0-9).
- blink_en  in  1  1 = colon blinks, 0 = colon steady on.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  colon/decimal point, active-low.
- an_n  out  4  digit enables, active-low; an_n[0] = minute units, an_n[3] = hour tens.
- digit_err  out  1  last captured snapshot contained an illegal digit.

Behaviour:
- Reset (asynchronous assert, active-low): seg_n=7'h7F, dp_n=1, an_n=4'hF, digit_err=0, snapshot=00:00, prescaler pc=0, digit index idx=0, frame counter=0, colon phase=1 (on).
- Snapshot:
  - On a cycle with time_valid=1, all four digits are captured together.
  - The display never shows a mix of old and new digits within one capture.
  - A captured value is used for outputs computed from the next cycle onward.
- Validation at capture. A digit is illegal if any of the following hold:
  - ms_hr>2;
  - ls_hr>9;
  - ms_hr==2 and ls_hr>3;
  - ms_min>5;
  - ls_min>9.
  - digit_err is registered: it goes high the cycle after an illegal capture and clears the cycle after the next legal capture.
  - digit_err is not sticky.
- Prescaler and digit index:
  - pc counts 0..SCAN_DIV-1 and wraps.
  - idx advances 0→1→2→3→0 when pc==SCAN_DIV-1.
  - One frame = 4*SCAN_DIV cycles.
- Outputs are registered (1-cycle latency from pc/idx/snapshot):
  - When pc==0, an_n=4'hF and seg_n=7'h7F (anti-ghost blank).
  - When pc≠0, an_n has only bit idx low, and seg_n shows the decoded digit idx.
- Decode (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - An illegal digit shows a dash, 7'h3F. For ms_hr==2 with ls_hr>3, the dash is on the hour-units digit only.
  - Blank = 7'h7F.
- Leading zero: with LZ_BLANK=1 and snapshot ms_hr==0, digit 3 shows blank, but its an_n bit still asserts normally.
- Colon:
  - dp_n=0 only while idx==2, pc≠0 and colon phase=1; otherwise dp_n=1.
  - The frame counter increments when idx wraps 3→0.
  - When it reaches BLINK_DIV-1 at that wrap, it resets to 0 and the phase toggles, if blink_en=1.
  - blink_en=0 forces phase=1 and holds the frame counter at 0.
- Simultaneous events: time_valid coinciding with a slot change or frame wrap needs no special handling. The new digit value first appears in the output register written two clocks after the strobe edge.
- Reset mid-frame returns all state to reset values immediately. Scanning restarts at idx=0, pc=0 on the first clock after release.
- Exactly one an_n bit is low at any cycle outside pc==0.

Test Plan:
1. Reset with SCAN_DIV=4: hold reset low for 3 cycles → an_n=F, seg_n=7F, dp_n=1 throughout. After release, pc=0 gives a blank cycle, then an_n=E for 3 cycles.
2. Load 12:35 with SCAN_DIV=4, LZ_BLANK=1 → per slot, excluding blank cycles: an_n=E/seg 12, an_n=D/seg 30, an_n=B/seg 24 with dp_n=0, an_n=7/seg 79. digit_err=0.
3. Load 09:59 → an_n=7 slot shows seg 7F. Load 10:00 → that slot shows seg 79.
4. Load 25:61 → digit_err=1 the cycle after the strobe. Digits: hr-units dash 3F, min-tens dash 3F, hr-tens 24, min-units 79. Then load 23:59 → digit_err returns to 0.
5. BLINK_DIV=2, blink_en=1 → dp_n is low in the idx 2 slots of frames 0-1, high in frames 2-3, and repeats. Dropping blink_en to 0 mid-frame gives dp_n low on the next idx 2 slot.
6. Assert reset when idx=2, pc=3, with snapshot 12:35 → all outputs reach reset values asynchronously. After release, the display shows 00:00 with the hour-tens digit blank, starting from digit 0.

Source files
------------

// File: rtl/clock_display_scanner.sv
// Multiplexed 4-digit 7-segment driver for the HH:MM clock counter.
// It captures a coherent snapshot, flags illegal digits, scans with an anti-ghost blank slot and blinks the colon.
module clock_display_scanner #(
    parameter int SCAN_DIV  = 16,
    parameter int BLINK_DIV = 64,
    parameter int LZ_BLANK  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       time_valid,
    input  logic [1:0] time_ms_hr,
    input  logic [3:0] time_ls_hr,
    input  logic [2:0] time_ms_min,
    input  logic [3:0] time_ls_min,
    input  logic       blink_en,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n,
    output logic       digit_err
);

    localparam int PC_W = $clog2(SCAN_DIV);
    localparam int FR_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(SCAN_DIV - 1);
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

    function automatic logic time_illegal(
        input logic [1:0] mh,
        input logic [3:0] lh,
        input logic [2:0] mm,
        input logic [3:0] lm
    );
        return (mh > 2'd2) || (lh > 4'd9) || ((mh == 2'd2) && (lh > 4'd3)) ||
               (mm > 3'd5) || (lm > 4'd9);
    endfunction

    logic [1:0]      ms_hr_q, ms_hr_d;
    logic [3:0]      ls_hr_q, ls_hr_d;
    logic [2:0]      ms_min_q, ms_min_d;
    logic [3:0]      ls_min_q, ls_min_d;
    logic            digit_err_q, digit_err_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [1:0]      idx_q, idx_d;
    logic [FR_W-1:0] frame_q, frame_d;
    logic            phase_q, phase_d;
    logic [6:0]      seg_n_q, seg_n_d;
    logic            dp_n_q, dp_n_d;
    logic [3:0]      an_n_q, an_n_d;

    logic            frame_wrap_s;
    logic [3:0]      digit_val_s;
    logic            digit_bad_s;
    logic [6:0]      glyph_s;

    // Snapshot capture: all four digits and the error flag update together on the strobe
    always_comb begin
        ms_hr_d     = ms_hr_q;
        ls_hr_d     = ls_hr_q;
        ms_min_d    = ms_min_q;
        ls_min_d    = ls_min_q;
        digit_err_d = digit_err_q;
        if (time_valid) begin
            ms_hr_d     = time_ms_hr;
            ls_hr_d     = time_ls_hr;
            ms_min_d    = time_ms_min;
            ls_min_d    = time_ls_min;
            digit_err_d = time_illegal(time_ms_hr, time_ls_hr, time_ms_min, time_ls_min);
        end else begin
            digit_err_d = digit_err_q;
        end
    end

    // Slot prescaler, digit index and colon blink frame counter
    always_comb begin
        pc_d         = pc_q;
        idx_d        = idx_q;
        frame_d      = frame_q;
        phase_d      = phase_q;
        frame_wrap_s = (pc_q == PC_LAST) && (idx_q == 2'd3);
        if (pc_q == PC_LAST) begin
            pc_d  = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            pc_d  = pc_q + PC_W'(1);
        end
        if (!blink_en) begin
            frame_d = '0;
            phase_d = 1'b1;
        end else if (frame_wrap_s) begin
            if (frame_q == FR_LAST) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FR_W'(1);
            end
        end else begin
            frame_d = frame_q;
        end
    end

    // Digit selection, validation, decode and the blank slot at pc == 0
    always_comb begin
        digit_val_s = 4'd0;
        digit_bad_s = 1'b0;
        case (idx_q)
            2'd0: begin
                digit_val_s = ls_min_q;
                digit_bad_s = (ls_min_q > 4'd9);
            end
            2'd1: begin
                digit_val_s = {1'b0, ms_min_q};
                digit_bad_s = (ms_min_q > 3'd5);
            end
            2'd2: begin
                digit_val_s = ls_hr_q;
                digit_bad_s = (ls_hr_q > 4'd9) || ((ms_hr_q == 2'd2) && (ls_hr_q > 4'd3));
            end
            2'd3: begin
                digit_val_s = {2'b00, ms_hr_q};
                digit_bad_s = (ms_hr_q > 2'd2);
            end
            default: begin
                digit_val_s = 4'd0;
                digit_bad_s = 1'b1;
            end
        endcase

        // Leading-zero blanking only hides the glyph; the anode still scans normally
        if (digit_bad_s) begin
            glyph_s = SEG_DASH;
        end else if ((LZ_BLANK != 0) && (idx_q == 2'd3) && (ms_hr_q == 2'd0)) begin
            glyph_s = SEG_BLANK;
        end else begin
            glyph_s = seg_decode(digit_val_s);
        end

        if (pc_q == '0) begin
            an_n_d  = 4'hF;
            seg_n_d = SEG_BLANK;
            dp_n_d  = 1'b1;
        end else begin
            an_n_d  = ~(4'b0001 << idx_q);
            seg_n_d = glyph_s;
            dp_n_d  = ~((idx_q == 2'd2) && phase_q);
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ms_hr_q     <= 2'd0;
            ls_hr_q     <= 4'd0;
            ms_min_q    <= 3'd0;
            ls_min_q    <= 4'd0;
            digit_err_q <= 1'b0;
            pc_q        <= '0;
            idx_q       <= 2'd0;
            frame_q     <= '0;
            phase_q     <= 1'b1;
            seg_n_q     <= SEG_BLANK;
            dp_n_q      <= 1'b1;
            an_n_q      <= 4'hF;
        end else begin
            ms_hr_q     <= ms_hr_d;
            ls_hr_q     <= ls_hr_d;
            ms_min_q    <= ms_min_d;
            ls_min_q    <= ls_min_d;
            digit_err_q <= digit_err_d;
            pc_q        <= pc_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            phase_q     <= phase_d;
            seg_n_q     <= seg_n_d;
            dp_n_q      <= dp_n_d;
            an_n_q      <= an_n_d;
        end
    end

    assign seg_n     = seg_n_q;
    assign dp_n      = dp_n_q;
    assign an_n      = an_n_q;
    assign digit_err = digit_err_q;

endmodule

// File: tb/tb_clock_display_scanner.sv
// Directed table-driven bench for clock_display_scanner with SCAN_DIV=4, BLINK_DIV=2, LZ_BLANK=1.
module tb_clock_display_scanner;

    localparam int SD = 4;
    localparam int BD = 2;

    logic       clock;
    logic       reset;
    logic       time_valid;
    logic [1:0] time_ms_hr;
    logic [3:0] time_ls_hr;
    logic [2:0] time_ms_min;
    logic [3:0] time_ls_min;
    logic       blink_en;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;
    logic       digit_err;

    clock_display_scanner #(.SCAN_DIV(SD), .BLINK_DIV(BD), .LZ_BLANK(1)) dut (
        .clock(clock), .reset(reset), .time_valid(time_valid),
        .time_ms_hr(time_ms_hr), .time_ls_hr(time_ls_hr),
        .time_ms_min(time_ms_min), .time_ls_min(time_ls_min),
        .blink_en(blink_en), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
        .digit_err(digit_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] mh;
        logic [3:0] lh;
        logic [2:0] mm;
        logic [3:0] lm;
        logic [6:0] s0, s1, s2, s3;
        logic       err;
    } vec_t;

    vec_t       vecs[11];
    logic [6:0] cur_segs[4];
    int         n_checks = 0;
    int         n_fail   = 0;

    // Timing reference: m_* is the scan state now held, e_* the state the visible outputs were built from
    int   m_pc, m_idx, m_frame, e_pc, e_idx;
    logic m_phase, e_phase;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pc <= 0; m_idx <= 0; m_frame <= 0; m_phase <= 1'b1;
            e_pc <= 0; e_idx <= 0; e_phase <= 1'b1;
        end else begin
            e_pc    <= m_pc;
            e_idx   <= m_idx;
            e_phase <= m_phase;
            m_pc    <= (m_pc == SD - 1) ? 0 : m_pc + 1;
            if (m_pc == SD - 1) m_idx <= (m_idx + 1) % 4;
            if (!blink_en) begin
                m_frame <= 0;
                m_phase <= 1'b1;
            end else if (m_pc == SD - 1 && m_idx == 3) begin
                if (m_frame == BD - 1) begin
                    m_frame <= 0;
                    m_phase <= ~m_phase;
                end else begin
                    m_frame <= m_frame + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_frame(input int n, input string tag);
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            ea = (e_pc == 0) ? 4'hF : ~(4'b0001 << e_idx);
            es = (e_pc == 0) ? 7'h7F : cur_segs[e_idx];
            ed = (e_pc != 0 && e_idx == 2 && e_phase) ? 1'b0 : 1'b1;
            check(tag, 16'({an_n, seg_n, dp_n}), 16'({ea, es, ed}));
        end
    endtask

    task automatic load(input vec_t v);
        @(negedge clock);
        time_ms_hr  = v.mh;
        time_ls_hr  = v.lh;
        time_ms_min = v.mm;
        time_ls_min = v.lm;
        time_valid  = 1'b1;
        @(negedge clock);
        time_valid  = 1'b0;
        check("digit_err_after_strobe", 16'(digit_err), 16'(v.err));
        cur_segs[0] = v.s0; cur_segs[1] = v.s1; cur_segs[2] = v.s2; cur_segs[3] = v.s3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        vecs[0]  = '{2'd1, 4'd2, 3'd3, 4'd5, 7'h12, 7'h30, 7'h24, 7'h79, 1'b0}; // 12:35
        vecs[1]  = '{2'd0, 4'd9, 3'd5, 4'd9, 7'h10, 7'h12, 7'h10, 7'h7F, 1'b0}; // 09:59
        vecs[2]  = '{2'd1, 4'd0, 3'd0, 4'd0, 7'h40, 7'h40, 7'h40, 7'h79, 1'b0}; // 10:00
        vecs[3]  = '{2'd2, 4'd5, 3'd6, 4'd1, 7'h79, 7'h3F, 7'h3F, 7'h24, 1'b1}; // 25:61
        vecs[4]  = '{2'd2, 4'd3, 3'd5, 4'd9, 7'h10, 7'h12, 7'h30, 7'h24, 1'b0}; // 23:59
        vecs[5]  = '{2'd2, 4'd0, 3'd0, 4'd0, 7'h40, 7'h40, 7'h40, 7'h24, 1'b0}; // 20:00
        vecs[6]  = '{2'd1, 4'd9, 3'd4, 4'd8, 7'h00, 7'h19, 7'h10, 7'h79, 1'b0}; // 19:48
        vecs[7]  = '{2'd0, 4'd7, 3'd1, 4'd6, 7'h02, 7'h79, 7'h78, 7'h7F, 1'b0}; // 07:16
        vecs[8]  = '{2'd3, 4'd0, 3'd0, 4'd0, 7'h40, 7'h40, 7'h40, 7'h3F, 1'b1}; // hour tens 3
        vecs[9]  = '{2'd1, 4'd10, 3'd0, 4'd0, 7'h40, 7'h40, 7'h3F, 7'h79, 1'b1}; // hour units 10
        vecs[10] = '{2'd0, 4'd0, 3'd0, 4'd12, 7'h3F, 7'h40, 7'h40, 7'h7F, 1'b1}; // minute units 12

        reset = 1'b0; time_valid = 1'b0; blink_en = 1'b1;
        time_ms_hr = 2'd0; time_ls_hr = 4'd0; time_ms_min = 3'd0; time_ls_min = 4'd0;
        cur_segs[0] = 7'h40; cur_segs[1] = 7'h40; cur_segs[2] = 7'h40; cur_segs[3] = 7'h7F;

        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("reset_hold", 16'({an_n, seg_n, dp_n, digit_err}), 16'({4'hF, 7'h7F, 1'b1, 1'b0}));
        end
        reset = 1'b1;

        // Six frames of 00:00 with the colon blinking every two frames
        check_frame(6 * 4 * SD, "blink_frames");
        check_frame(SD, "blink_frame6_slot0");
        blink_en = 1'b0;
        check_frame(4 * SD, "blink_disable");

        foreach (vecs[i]) begin
            load(vecs[i]);
            check_frame(4 * SD, $sformatf("vec%0d_frame", i));
            check("digit_err_held", 16'(digit_err), 16'(vecs[i].err));
        end

        // Reset mid-scan at idx=2, pc=3 with 12:35 on display
        load(vecs[0]);
        found = 1'b0;
        for (int k = 0; k < 8 * SD; k++) begin
            if (m_idx == 2 && m_pc == SD - 1) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("reach_idx2_pc3", 16'(found), 16'(1'b1));
        reset = 1'b0;
        #1;
        check("async_reset", 16'({an_n, seg_n, dp_n, digit_err}), 16'({4'hF, 7'h7F, 1'b1, 1'b0}));
        @(negedge clock);
        check("reset_held", 16'({an_n, seg_n, dp_n, digit_err}), 16'({4'hF, 7'h7F, 1'b1, 1'b0}));
        reset = 1'b1;
        cur_segs[0] = 7'h40; cur_segs[1] = 7'h40; cur_segs[2] = 7'h40; cur_segs[3] = 7'h7F;
        check_frame(4 * SD, "post_reset_frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
